// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, PC sequencer states and ALU opcodes.
// Used by the decoder, the ALU and pc_unit so they agree on encodings.
package cpu_pkg;

    localparam int PC_W   = 10;
    localparam int LUT_AW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } pc_state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_BEQ = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_SHL = 3'b110;
    localparam logic [2:0] ALU_SHR = 3'b111;

    localparam logic [7:0] BEQ_EQUAL = 8'h00;

    function automatic logic beq_taken(input logic       is_br,
                                       input logic [7:0] res);
        return is_br && (res == BEQ_EQUAL);
    endfunction

endpackage

// File: rtl/branch_lut.sv
// Branch-target table: register array, async read, sync write.
// Every entry clears on asynchronous reset.
module branch_lut
    import cpu_pkg::*;
#(
    parameter int AW = LUT_AW,
    parameter int DW = PC_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pc_unit.sv
// Program counter and IDLE/RUN/HALT sequencer with LUT branch targets.
// PCU_REL_BRANCH_EN: taken branches add the signed LUT entry to pc.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int PC_W   = cpu_pkg::PC_W,
    parameter int LUT_AW = cpu_pkg::LUT_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    input  logic              is_branch,
    input  logic [7:0]        alu_result,
    input  logic [LUT_AW-1:0] lut_idx,
    input  logic              halt_req,
    input  logic              lut_we,
    input  logic [LUT_AW-1:0] lut_waddr,
    input  logic [PC_W-1:0]   lut_wdata,
    output logic [PC_W-1:0]   pc,
    output logic              running,
    output logic              done
);

    pc_state_t       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            running_q, running_d;
    logic            done_q, done_d;
    logic [PC_W-1:0] lut_rdata;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] br_target;
    logic            lut_wr_en;

    assign lut_wr_en = lut_we && (state_q == IDLE);

    branch_lut #(
        .AW (LUT_AW),
        .DW (PC_W)
    ) u_lut (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (lut_wr_en),
        .waddr_i (lut_waddr),
        .wdata_i (lut_wdata),
        .raddr_i (lut_idx),
        .rdata_o (lut_rdata)
    );

    assign pc_inc = pc_q + PC_W'(1);

`ifdef PCU_REL_BRANCH_EN
    // Two's-complement add wraps naturally at PC_W bits
    assign br_target = pc_q + lut_rdata;
`else
    assign br_target = lut_rdata;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                pc_d = '0;
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stall) begin
                    pc_d = pc_q;
                end else if (halt_req) begin
                    state_d = HALT;
                    done_d  = 1'b1;
                end else if (beq_taken(is_branch, alu_result)) begin
                    pc_d = br_target;
                end else begin
                    pc_d = pc_inc;
                end
            end
            HALT: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
            end
        endcase
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign pc      = pc_q;
    assign running = running_q;
    assign done    = done_q;

endmodule
